// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out engine: default 640x480@60 timing,
// the TinyVGA pin map, the 4x4 ordered-dither matrix and the pixel tag
// that travels down the delay line alongside each request.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // TinyVGA: {hsync, B[lo], G[lo], R[lo], vsync, B[hi], G[hi], R[hi]}
    localparam int PIN_R_HI  = 0;
    localparam int PIN_G_HI  = 1;
    localparam int PIN_B_HI  = 2;
    localparam int PIN_VSYNC = 3;
    localparam int PIN_R_LO  = 4;
    localparam int PIN_G_LO  = 5;
    localparam int PIN_B_LO  = 6;
    localparam int PIN_HSYNC = 7;

    // Bayer entry (row, col) lives at nibble row*4+col.
    // Rows: {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}
    localparam logic [63:0] BAYER4X4 = 64'h5D7F_91B3_6E4C_A280;

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic [1:0] x_lo;
        logic [1:0] y_lo;
    } pix_tag_t;

    localparam pix_tag_t TAG_IDLE = '{active: 1'b0, hsync: 1'b0, vsync: 1'b0,
                                      x_lo: 2'b00, y_lo: 2'b00};

    function automatic logic [3:0] bayer4x4(input logic [1:0] row, input logic [1:0] col);
        return BAYER4X4[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: h/v counters, visible-area and sync-window decode, and the
// request interface to the renderer. Counting starts one clock after reset.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       o_req,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_frame_start,
    output logic       o_line_start,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       r_running;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       w_h_vis;
    logic       w_v_vis;
    logic       w_origin;

    // Run flag and raster counters; counters hold at 0 until running is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
            r_h       <= 10'd0;
            r_v       <= 10'd0;
        end else begin
            r_running <= 1'b1;
            if (r_running) begin
                if (r_h == H_LAST) begin
                    r_h <= 10'd0;
                    if (r_v == V_LAST) begin
                        r_v <= 10'd0;
                    end else begin
                        r_v <= r_v + 10'd1;
                    end
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign w_h_vis  = (r_h < H_VIS_END);
    assign w_v_vis  = (r_v < V_VIS_END);
    assign w_origin = (r_h == 10'd0);

    assign o_x           = r_h;
    assign o_y           = r_v;
    assign o_active      = r_running & w_h_vis & w_v_vis;
    assign o_req         = o_active;
    assign o_line_start  = r_running & w_origin;
    assign o_frame_start = r_running & w_origin & (r_v == 10'd0);
    assign o_hsync       = (r_h >= H_SYNC_BEG) & (r_h < H_SYNC_END);
    assign o_vsync       = (r_v >= V_SYNC_BEG) & (r_v < V_SYNC_END);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out top: aligns timing with the renderer's returned colour via a
// PIPE_LAT-deep tag delay line, applies optional ordered dither and
// saturating quantisation, blanks outside the visible area and registers the
// TinyVGA-packed pins.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   IN_BITS  = 4,
    parameter int   OUT_BITS = 2,
    parameter int   PIPE_LAT = 2,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dither_en,
    output logic                 req,
    output logic [9:0]           x,
    output logic [9:0]           y,
    output logic                 frame_start,
    output logic                 line_start,
    input  logic [3*IN_BITS-1:0] rgb_in,
    output logic [7:0]           uo_out
);

    localparam int               DROP   = IN_BITS - OUT_BITS;
    localparam logic [IN_BITS-1:0] IN_MAX = {IN_BITS{1'b1}};
    localparam logic [7:0]       PINS_IDLE = {~SYNC_POL, 3'b000, ~SYNC_POL, 3'b000};

    logic          w_active;
    logic          w_hsync;
    logic          w_vsync;
    pix_tag_t      w_tag;
    pix_tag_t      w_tag_al;
    pix_tag_t      r_pipe [PIPE_LAT];
    logic          r_dither;
    logic [3:0]    w_thr;
    logic [OUT_BITS-1:0] w_q_r;
    logic [OUT_BITS-1:0] w_q_g;
    logic [OUT_BITS-1:0] w_q_b;
    logic [7:0]    w_pins;
    logic [7:0]    r_pins;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_req         (req),
        .o_x           (x),
        .o_y           (y),
        .o_frame_start (frame_start),
        .o_line_start  (line_start),
        .o_active      (w_active),
        .o_hsync       (w_hsync),
        .o_vsync       (w_vsync)
    );

    // Add the dither threshold, clamp at full scale, keep the top OUT_BITS
    function automatic logic [OUT_BITS-1:0] quantise(input logic [IN_BITS-1:0] chan,
                                                    input logic [3:0] thr);
        logic [IN_BITS+3:0] sum;
        sum = {4'b0000, chan} + {{IN_BITS{1'b0}}, thr};
        sum = (sum > {4'b0000, IN_MAX}) ? {4'b0000, IN_MAX} : sum;
        return sum[IN_BITS-1 -: OUT_BITS];
    endfunction

    assign w_tag    = {w_active, w_hsync, w_vsync, x[1:0], y[1:0]};
    assign w_tag_al = r_pipe[PIPE_LAT-1];

    // Tag delay line so timing lines up with the colour the renderer returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipe[i] <= TAG_IDLE;
            end
        end else begin
            r_pipe[0] <= w_tag;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Dither enable is frozen for a whole frame at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dither <= 1'b0;
        end else if (frame_start) begin
            r_dither <= dither_en;
        end
    end

    // Quantise, blank and pack the aligned pixel into TinyVGA order
    always_comb begin
        w_thr  = 4'd0;
        w_q_r  = {OUT_BITS{1'b0}};
        w_q_g  = {OUT_BITS{1'b0}};
        w_q_b  = {OUT_BITS{1'b0}};
        w_pins = PINS_IDLE;
        if (r_dither) begin
            w_thr = bayer4x4(w_tag_al.y_lo, w_tag_al.x_lo) >> (4 - DROP);
        end else begin
            w_thr = 4'd0;
        end
        if (w_tag_al.active) begin
            w_q_r = quantise(rgb_in[3*IN_BITS-1 -: IN_BITS], w_thr);
            w_q_g = quantise(rgb_in[2*IN_BITS-1 -: IN_BITS], w_thr);
            w_q_b = quantise(rgb_in[IN_BITS-1   -: IN_BITS], w_thr);
        end else begin
            w_q_r = {OUT_BITS{1'b0}};
            w_q_g = {OUT_BITS{1'b0}};
            w_q_b = {OUT_BITS{1'b0}};
        end
        w_pins[PIN_HSYNC] = w_tag_al.hsync ? SYNC_POL : ~SYNC_POL;
        w_pins[PIN_VSYNC] = w_tag_al.vsync ? SYNC_POL : ~SYNC_POL;
        w_pins[PIN_R_HI]  = w_q_r[OUT_BITS-1];
        w_pins[PIN_G_HI]  = w_q_g[OUT_BITS-1];
        w_pins[PIN_B_HI]  = w_q_b[OUT_BITS-1];
        w_pins[PIN_R_LO]  = w_q_r[0];
        w_pins[PIN_G_LO]  = w_q_g[0];
        w_pins[PIN_B_LO]  = w_q_b[0];
    end

    // Output pin register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pins <= PINS_IDLE;
        end else begin
            r_pins <= w_pins;
        end
    end

    assign uo_out = r_pins;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a small-raster 2-bit build, a small-raster 1-bit
// build and a default 640x480 build run side by side from one reset. The
// bench plays the renderer and predicts every pin from raster arithmetic.
module tb_vga_scanout;

    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int M_RAND = 0, M_CONST = 1, M_DIRECT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dither_en = 1'b0;
    logic [11:0] rgb_s = 12'h000;
    logic [11:0] rgb_zero = 12'h000;

    logic       req_a, fs_a, ls_a, req_b, fs_b, ls_b, req_d, fs_d, ls_d;
    logic [9:0] x_a, y_a, x_b, y_b, x_d, y_d;
    logic [7:0] uo_a, uo_b, uo_d;

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)) u_dut (
        .clk(clk), .rst_n(rst_n), .dither_en(dither_en), .req(req_a), .x(x_a), .y(y_a),
        .frame_start(fs_a), .line_start(ls_a), .rgb_in(rgb_s), .uo_out(uo_a));

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                  .OUT_BITS(1)) u_one (
        .clk(clk), .rst_n(rst_n), .dither_en(dither_en), .req(req_b), .x(x_b), .y(y_b),
        .frame_start(fs_b), .line_start(ls_b), .rgb_in(rgb_s), .uo_out(uo_b));

    vga_scanout u_def (
        .clk(clk), .rst_n(rst_n), .dither_en(dither_en), .req(req_d), .x(x_d), .y(y_d),
        .frame_start(fs_d), .line_start(ls_d), .rgb_in(rgb_zero), .uo_out(uo_d));

    int checks = 0;
    int failures = 0;
    int k = -1;
    int mode = M_RAND;
    logic [11:0] const_col = 12'h000;
    logic [11:0] tcol = 12'h000;
    int tx = 0, ty = 0;
    bit cap_valid = 1'b0;
    logic [7:0] cap_val = 8'h00;
    bit cnt_en = 1'b0;
    int cnt_frame = 0, cnt1 = 0, cnt2 = 0;
    logic [11:0] col_hist [64];
    bit          req_hist [64];
    logic        dith_frame [64];
    int bayer_t [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    typedef struct {
        int          vx;
        int          vy;
        logic [11:0] col;
        logic        dith;
        logic [7:0]  exp_pins;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (k=%0d)", name, k);
    endtask

    function automatic logic [7:0] pix_exp(input int kp, input logic [11:0] col,
                                           input logic dith, input int ob);
        int h, v, d, thr, c, s;
        int q [3];
        logic act, hs, vs;
        h   = kp % HT;
        v   = (kp / HT) % VT;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
        vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
        d   = 4 - ob;
        thr = dith ? (bayer_t[(v % 4) * 4 + (h % 4)] * (1 << d)) / 16 : 0;
        for (int ch = 0; ch < 3; ch++) begin
            c = int'((col >> (8 - 4 * ch)) & 12'h00F);
            s = c + thr;
            if (s > 15) s = 15;
            q[ch] = act ? (s >> d) : 0;
        end
        return {~hs, 1'(q[2]), 1'(q[1]), 1'(q[0]),
                ~vs, 1'(q[2] >> (ob - 1)), 1'(q[1] >> (ob - 1)), 1'(q[0] >> (ob - 1))};
    endfunction

    function automatic logic [11:0] gen_col(input int h, input int v);
        if (mode == M_RAND)  return 12'($urandom_range(0, 4095));
        if (mode == M_CONST) return const_col;
        return (h == tx && v == ty) ? tcol : 12'h000;
    endfunction

    initial begin
        forever #5 clk = ~clk;
    end

    // Renderer model and per-cycle checker, evaluated 1 time unit after each edge
    initial begin
        int h, v, kp, hd, ex_hs;
        bit mreq;
        logic [7:0] ep;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) k = -1; else k = k + 1;
            if (k >= 1 && ((k - 1) % FT) == 0) dith_frame[((k - 1) / FT) % 64] = dither_en;
            h = 0; v = 0; mreq = 1'b0;
            if (k >= 0) begin
                h = k % HT;
                v = (k / HT) % VT;
                mreq = (h < HA) && (v < VA);
                req_hist[k % 64] = mreq;
                if (mreq) col_hist[k % 64] = gen_col(h, v);
            end
            if (k >= 2 && req_hist[(k - 2) % 64]) rgb_s = col_hist[(k - 2) % 64];
            else if (mode == M_RAND) rgb_s = 12'($urandom_range(1, 4095));
            else rgb_s = 12'h000;

            chk("timing", {req_a, x_a, y_a, fs_a, ls_a},
                (k >= 0) ? {mreq, 10'(h), 10'(v), (k % FT) == 0, (k % HT) == 0} : 23'd0);

            kp = k - 3;
            if (kp >= 0) begin
                ep = pix_exp(kp, col_hist[kp % 64], dith_frame[(kp / FT) % 64], 2);
                chk("pins", uo_a, ep);
                ep = pix_exp(kp, col_hist[kp % 64], dith_frame[(kp / FT) % 64], 1);
                chk("one_bit_pins", uo_b, ep);
                if (mode == M_DIRECT && (kp % HT) == tx && ((kp / HT) % VT) == ty) begin
                    cap_valid = 1'b1;
                    cap_val   = uo_a;
                end
                if (cnt_en && (kp / FT) == cnt_frame && (kp % HT) < 4 && ((kp / HT) % VT) < 4) begin
                    if ({uo_a[0], uo_a[4]} == 2'd2) cnt2++;
                    if ({uo_a[0], uo_a[4]} == 2'd1) cnt1++;
                end
            end else begin
                chk("pins_idle", uo_a, 8'h88);
                chk("one_bit_idle", uo_b, 8'h88);
            end
            chk("one_bit_hi_eq_lo", uo_b[6:4], uo_b[2:0]);

            if (k >= 0 && k < 2400) begin
                hd    = (k - 3) % 800;
                ex_hs = (k >= 3 && hd >= 656 && hd < 752) ? 0 : 1;
                chk("def_pins", uo_d, {1'(ex_hs), 3'b000, 1'b1, 3'b000});
                chk("def_line", {req_d, ls_d, x_d}, {(k % 800) < 640, (k % 800) == 0, 10'(k % 800)});
            end
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(k >= 0 && (k % FT) == 0) && n < 2 * FT);
        if (n >= 2 * FT) fail_now("frame_wait");
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(k >= 0 && (k % FT) == ph) && n < 2 * FT);
        if (n >= 2 * FT) fail_now("phase_wait");
    endtask

    task automatic get_cap(output logic [7:0] val);
        int n = 0;
        while (!cap_valid && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        if (!cap_valid) fail_now("capture_wait");
        val = cap_val;
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_pins"}, uo_a, 8'h88);
        chk({tag, "_def_pins"}, uo_d, 8'h88);
        chk({tag, "_req_xy"}, {req_a, x_a, y_a, fs_a, ls_a}, 23'd0);
    endtask

    // Directed sequences
    initial begin
        vec_t vecs [8];
        logic [7:0] got;
        vecs[0] = '{5, 0, 12'hFFF, 1'b0, 8'hFF};
        vecs[1] = '{0, 0, 12'h666, 1'b0, 8'hF8};
        vecs[2] = '{0, 0, 12'h666, 1'b1, 8'hF8};
        vecs[3] = '{1, 0, 12'h666, 1'b1, 8'h8F};
        vecs[4] = '{3, 2, 12'hFFF, 1'b1, 8'hFF};
        vecs[5] = '{2, 1, 12'h63C, 1'b1, 8'hED};
        vecs[6] = '{0, 0, 12'h000, 1'b1, 8'h88};
        vecs[7] = '{7, 3, 12'h1F1, 1'b0, 8'hAA};
        for (int i = 0; i < 64; i++) begin
            col_hist[i] = 12'h000; req_hist[i] = 1'b0; dith_frame[i] = 1'b0;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_now("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2 chk("first_req", {req_a, x_a, y_a}, {1'b1, 10'd0, 10'd0});

        // Random colours with dither toggled at random points
        mode = M_RAND;
        repeat (8 * FT) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) dither_en = ~dither_en;
        end

        // Ordered dither split of a constant mid value over the first 4x4 block
        mode = M_CONST; const_col = 12'h666; dither_en = 1'b1;
        wait_frame();
        cnt_frame = k / FT; cnt1 = 0; cnt2 = 0; cnt_en = 1'b1;
        wait_phase(5 * HT);
        cnt_en = 1'b0;
        chk("dither_on_cnt2", cnt2, 8);
        chk("dither_on_cnt1", cnt1, 8);
        dither_en = 1'b0;
        wait_frame();
        cnt_frame = k / FT; cnt1 = 0; cnt2 = 0; cnt_en = 1'b1;
        wait_phase(5 * HT);
        cnt_en = 1'b0;
        chk("dither_off_cnt1", cnt1, 16);
        chk("dither_off_cnt2", cnt2, 0);

        // Full-scale input with dither must saturate
        const_col = 12'hFFF; dither_en = 1'b1;
        wait_frame();
        wait_frame();

        // Single-pixel vectors
        mode = M_DIRECT;
        for (int i = 0; i < 8; i++) begin
            tx = vecs[i].vx; ty = vecs[i].vy; tcol = vecs[i].col; dither_en = vecs[i].dith;
            wait_frame();
            cap_valid = 1'b0;
            get_cap(got);
            chk($sformatf("vec%0d", i), got, vecs[i].exp_pins);
        end

        // Mid-frame dither toggle takes effect only from the next frame
        tx = 1; ty = 4; tcol = 12'h666; dither_en = 1'b0;
        wait_frame();
        cap_valid = 1'b0;
        wait_phase(2 * HT);
        dither_en = 1'b1;
        get_cap(got);
        chk("toggle_same_frame", got, 8'hF8);
        wait_frame();
        cap_valid = 1'b0;
        get_cap(got);
        chk("toggle_next_frame", got, 8'h8F);

        // Asynchronous reset in the middle of a frame, then restart
        mode = M_RAND;
        wait_phase(FT / 2);
        rst_n = 1'b0;
        #1 check_reset_now("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FT) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
